kggramas_to_gramas: RTL
=======================

Name: kggramas_to_gramas

Overview:
- Sequential converter from the scale's kg/grams display format back to a binary gram count. It is the inverse of the existing grams-to-kg/grams path.
- Input is four packed BCD digits: 1 kg digit followed by 3 gram digits (hundreds, tens, units).
- Output is a 12-bit binary gram value with a start/busy/done handshake.
- Used for keypad tare/setpoint entry and for round-trip checking of the display path.

Parameters:
- NDIG, 4, number of BCD digits processed, most significant first.
- OUT_W, 12, width of the binary gram output.
- MAX_G, 4095, saturation ceiling for the output (2^OUT_W - 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- kggramas  input  16  packed BCD: [15:12] kg, [11:8] hundreds, [7:4] tens, [3:0] units.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when gramas, erro and sat are updated.
- gramas  output  12  binary grams result; holds its value between conversions.
- erro  output  1  the last conversion saw a digit greater than 9.
- sat  output  1  the last conversion exceeded MAX_G and was clamped.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0, done=0, gramas=0, erro=0, sat=0.
  - Internal accumulator, digit index, latched input and error flag all clear.
  - Reset mid-conversion aborts it: no done pulse; outputs return to 0.
- States: IDLE, CONV.
- IDLE:
  - On a clk edge with start=1: latch kggramas into an internal register, acc=0, idx=NDIG-1, err_acc=0, go to CONV, busy=1.
  - kggramas may change after that edge without affecting the result.
- CONV, one digit per edge:
  - acc <= acc*10 + d[idx], with acc 14 bits wide (max 9999, no overflow).
  - err_acc <= err_acc | (d[idx] > 9).
  - idx decrements each edge.
- On the edge that consumes d[0] (the 4th CONV edge):
  - Result and flags are registered from acc*10 + d[0] and err_acc | (d[0] > 9).
  - done=1 for exactly one cycle, busy=0, state returns to IDLE.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+NDIG (4 edges).
- Result rules, priority top-down:
  - Any invalid digit: gramas=0, erro=1, sat=0.
  - Else if value > MAX_G: gramas=MAX_G, sat=1, erro=0.
  - Else: gramas=value, erro=0, sat=0.
- erro and sat hold until the next done pulse or reset.
- Handshake edge cases:
  - start while busy is ignored and not queued.
  - start held high continuously: a new conversion begins on the first edge in IDLE after done. Back-to-back throughput is one result per NDIG+1 cycles.
  - done and busy are never high in the same cycle.
- Invalid digits do not shorten the conversion: always exactly NDIG CONV cycles.

Test Plan:
- Reset: rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, gramas=0, erro=0, sat=0 throughout.
- Nominal: kggramas=16'h0500, 1-cycle start -> busy for 4 cycles, then done pulse with gramas=500, erro=0, sat=0. Round trip of the 500 g stimulus used on the display path.
- Saturation: kggramas=16'h4096 -> gramas=4095, sat=1. Then 16'h4095 -> gramas=4095, sat=0. Then 16'h9999 -> gramas=4095, sat=1.
- Invalid digit: kggramas=16'h0A00 -> gramas=0, erro=1, sat=0. Then 16'hF999 (invalid and over range) -> erro=1, sat=0, gramas=0.
- Handshake: start held high 12 cycles with input 16'h1234 -> done pulses spaced 5 cycles apart, each with gramas=1234. Changing kggramas while busy does not alter the in-flight result.
- Abort: start 16'h2000, assert rst_n=0 after 2 CONV cycles -> no done pulse, outputs 0. After release, new start with 16'h0007 -> gramas=7 after 4 cycles.

Source files
------------

// File: rtl/kggramas_to_gramas.sv
// Converts packed BCD kg/grams digits (kg, hundreds, tens, units) into a saturated binary gram count.
// Latency: start sampled at edge E0, done pulses in the cycle after edge E0+NDIG.
// Backpressure: none; start is ignored while busy and is never queued.
module kggramas_to_gramas #(
    parameter int NDIG  = 4,
    parameter int OUT_W = 12,
    parameter int MAX_G = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NDIG-1:0]    kggramas,
    output logic                 busy,
    output logic                 done,
    output logic [OUT_W-1:0]     gramas,
    output logic                 erro,
    output logic                 sat
);

    localparam int ACC_W = $clog2(10 ** NDIG);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_G);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_G);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [4*NDIG-1:0]   lat;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_nxt;
    logic [IDX_W-1:0]    idx;
    logic                err_acc;
    logic                err_nxt;
    logic [3:0]          dig;
    logic                last;

    // Digit currently being folded in, most significant first.
    always_comb begin
        dig     = lat[{idx, 2'b00} +: 4];
        acc_nxt = acc * ACC_W'(10) + ACC_W'(dig);
        err_nxt = err_acc | (dig > 4'd9);
        last    = (idx == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat     <= '0;
            acc     <= '0;
            idx     <= '0;
            err_acc <= 1'b0;
            done    <= 1'b0;
            gramas  <= '0;
            erro    <= 1'b0;
            sat     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat     <= kggramas;
                        acc     <= '0;
                        idx     <= IDX_W'(NDIG - 1);
                        err_acc <= 1'b0;
                    end
                end
                CONV: begin
                    acc     <= acc_nxt;
                    err_acc <= err_nxt;
                    idx     <= idx - IDX_W'(1);
                    if (last) begin
                        done <= 1'b1;
                        // An invalid digit outranks saturation.
                        if (err_nxt) begin
                            gramas <= '0;
                            erro   <= 1'b1;
                            sat    <= 1'b0;
                        end else if (acc_nxt > MAX_ACC) begin
                            gramas <= MAX_OUT;
                            erro   <= 1'b0;
                            sat    <= 1'b1;
                        end else begin
                            gramas <= acc_nxt[OUT_W-1:0];
                            erro   <= 1'b0;
                            sat    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
